// File: rtl/rd_data_ctrl_if.sv
//------------------------------------------------------------------------------
// Module     : rd_data_ctrl_if
// Description: Bus bundle for the DDR2 read-data controller: job request and
//              status, MIG app_af command port, MIG read-data return, and the
//              downstream user read FIFO write port.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface rd_data_ctrl_if #(
   parameter int DATA_WIDTH = 64
);
   // job control
   logic                  rd_req;
   logic [30:0]           rd_start_addr;
   logic [15:0]           rd_burst_num;
   logic                  rd_busy;
   logic                  rd_done;
   logic                  rd_err;
   // MIG command port
   logic                  app_af_afull;
   logic                  app_af_wren;
   logic [30:0]           app_af_addr;
   logic [2:0]            app_af_cmd;
   // MIG read data
   logic                  rd_data_valid;
   logic [DATA_WIDTH-1:0] rd_data_fifo_out;
   // downstream FIFO
   logic                  rd_fifo_prog_full;
   logic                  rd_fifo_wr;
   logic [DATA_WIDTH-1:0] rd_fifo_din;

   // controller side
   modport master (
      input  rd_req, rd_start_addr, rd_burst_num,
      input  app_af_afull, rd_data_valid, rd_data_fifo_out, rd_fifo_prog_full,
      output rd_busy, rd_done, rd_err,
      output app_af_wren, app_af_addr, app_af_cmd,
      output rd_fifo_wr, rd_fifo_din
   );

   // job source / MIG / FIFO side
   modport slave (
      output rd_req, rd_start_addr, rd_burst_num,
      output app_af_afull, rd_data_valid, rd_data_fifo_out, rd_fifo_prog_full,
      input  rd_busy, rd_done, rd_err,
      input  app_af_wren, app_af_addr, app_af_cmd,
      input  rd_fifo_wr, rd_fifo_din
   );
endinterface

`default_nettype wire

// File: rtl/rd_data_ctrl.sv
//------------------------------------------------------------------------------
// Module     : rd_data_ctrl
// Description: DDR2 read path controller. Accepts a read job, issues MIG read
//              commands credit-limited against downstream FIFO space, and
//              forwards returned read beats into the user read FIFO.
//              Optional feature macro: RD_DATA_CHECK_EN (incrementing-pattern
//              data checker driving rd_err).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rd_data_ctrl #(
   parameter int          DATA_WIDTH      = 64,
   parameter int          BURST_BEATS     = 2,
   parameter int          ADDR_INC        = 4,
   parameter int          MAX_OUTSTANDING = 8,
   parameter logic [30:0] ADDR_MAX        = 31'h7FFFFFFC
) (
   input  wire logic      sys_clk,
   input  wire logic      reset,          // asynchronous, active low
   input  wire logic      phy_init_done,
   rd_data_ctrl_if.master bus
);

   localparam int          BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BURST_BEATS - 1);
   localparam logic [7:0]  c_max_out   = 8'(MAX_OUTSTANDING);
   localparam logic [30:0] c_addr_inc  = 31'(ADDR_INC);
   localparam logic [2:0]  c_cmd_read  = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [30:0]           addr_q, addr_d;          // next command address
   logic [15:0]           cmds_left_q, cmds_left_d;
   logic [7:0]            outst_q, outst_d;        // commands with data still pending
   logic [BEAT_W-1:0]     beat_q, beat_d;          // beat index within current burst
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  wren_q, wren_d;
   logic [30:0]           af_addr_q, af_addr_d;
   logic [2:0]            cmd_q, cmd_d;
   logic                  fifo_wr_q, fifo_wr_d;
   logic [DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;

   logic w_job_accept;
   logic w_issue;
   logic w_beat_ok;
   logic w_spurious;
   logic w_burst_end;
   logic w_chk_mismatch;

   assign w_job_accept = (state_q == ST_IDLE) && bus.rd_req && phy_init_done;

   // A command goes out only when the MIG can take it and the FIFO is
   // guaranteed to absorb its data, since read data cannot be back-pressured.
   assign w_issue = (state_q == ST_ISSUE) && phy_init_done && !bus.app_af_afull &&
                    !bus.rd_fifo_prog_full && (outst_q < c_max_out) &&
                    (cmds_left_q != 16'd0);

   // Beats are only owned when a command is outstanding; anything else is stray.
   assign w_beat_ok   = bus.rd_data_valid && (outst_q != 8'd0) && busy_q;
   assign w_spurious  = bus.rd_data_valid && (outst_q == 8'd0);
   assign w_burst_end = w_beat_ok && (beat_q == c_last_beat);

`ifdef RD_DATA_CHECK_EN
   logic [31:0] chk_cnt_q, chk_cnt_d;

   assign w_chk_mismatch = w_beat_ok &&
                           (bus.rd_data_fifo_out != {(DATA_WIDTH/32){chk_cnt_q}});

   // Expected-pattern counter restarts with each accepted job
   always_comb begin
      chk_cnt_d = chk_cnt_q;
      if (w_job_accept)
         chk_cnt_d = 32'd0;
      else if (w_beat_ok)
         chk_cnt_d = chk_cnt_q + 32'd1;
   end

   // Pattern counter register
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset)
         chk_cnt_q <= 32'd0;
      else
         chk_cnt_q <= chk_cnt_d;
   end
`else
   assign w_chk_mismatch = 1'b0;
`endif

   // Next-state computation for job FSM, counters and registered outputs
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cmds_left_d = cmds_left_q;
      outst_d     = outst_q;
      beat_d      = beat_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      wren_d      = w_issue;
      af_addr_d   = af_addr_q;
      cmd_d       = w_issue ? c_cmd_read : 3'b000;
      fifo_wr_d   = w_beat_ok;
      fifo_din_d  = fifo_din_q;

      unique case (state_q)
         ST_IDLE: begin
            if (w_job_accept) begin
               if (bus.rd_burst_num != 16'd0) begin
                  state_d     = ST_ISSUE;
                  addr_d      = bus.rd_start_addr;
                  cmds_left_d = bus.rd_burst_num;
                  busy_d      = 1'b1;
               end else begin
                  done_d      = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (w_issue && (cmds_left_q == 16'd1))
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // outst reaches 0 only on a burst's final beat, which is being
            // written to the FIFO in this cycle.
            if (outst_q == 8'd0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (w_issue) begin
         af_addr_d   = addr_q;
         addr_d      = (addr_q == ADDR_MAX) ? 31'd0 : addr_q + c_addr_inc;
         cmds_left_d = cmds_left_q - 16'd1;
      end

      if (w_beat_ok) begin
         fifo_din_d = bus.rd_data_fifo_out;
         beat_d     = w_burst_end ? '0 : beat_q + 1'b1;
      end

      // issue and burst completion in the same cycle cancel out
      if (w_issue && !w_burst_end)
         outst_d = outst_q + 8'd1;
      else if (!w_issue && w_burst_end)
         outst_d = outst_q - 8'd1;

      if (w_job_accept)
         err_d = 1'b0;
      if (w_spurious || w_chk_mismatch)
         err_d = 1'b1;
   end

   // State, counter and output registers
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cmds_left_q <= '0;
         outst_q     <= '0;
         beat_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wren_q      <= 1'b0;
         af_addr_q   <= '0;
         cmd_q       <= '0;
         fifo_wr_q   <= 1'b0;
         fifo_din_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cmds_left_q <= cmds_left_d;
         outst_q     <= outst_d;
         beat_q      <= beat_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         wren_q      <= wren_d;
         af_addr_q   <= af_addr_d;
         cmd_q       <= cmd_d;
         fifo_wr_q   <= fifo_wr_d;
         fifo_din_q  <= fifo_din_d;
      end
   end

   assign bus.rd_busy     = busy_q;
   assign bus.rd_done     = done_q;
   assign bus.rd_err      = err_q;
   assign bus.app_af_wren = wren_q;
   assign bus.app_af_addr = af_addr_q;
   assign bus.app_af_cmd  = cmd_q;
   assign bus.rd_fifo_wr  = fifo_wr_q;
   assign bus.rd_fifo_din = fifo_din_q;

endmodule

`default_nettype wire

// File: tb/tb_rd_data_ctrl.sv
//------------------------------------------------------------------------------
// Module     : tb_rd_data_ctrl
// Description: Self-checking bench for rd_data_ctrl with a MIG read-return
//              model and address/data scoreboards.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rd_data_ctrl;

   localparam int          DW       = 64;
   localparam int          MAX_OUT  = 8;
   localparam logic [30:0] ADDR_MAX = 31'h7FFFFFFC;

   logic sys_clk = 1'b0;
   logic reset   = 1'b1;
   logic phy_init_done = 1'b0;

   rd_data_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   rd_data_ctrl #(
      .DATA_WIDTH      (DW),
      .BURST_BEATS     (2),
      .ADDR_INC        (4),
      .MAX_OUTSTANDING (MAX_OUT),
      .ADDR_MAX        (ADDR_MAX)
   ) dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .phy_init_done (phy_init_done),
      .bus           (bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [30:0] addr;
      int          num;
      int          delay;
      int          exp_cmds;
      int          exp_beats;
      int          exp_max_outst;
   } vec_t;

   vec_t vecs[4];

   int n_checks = 0;
   int n_fail   = 0;

   logic [30:0] exp_addr_q[$];
   logic [63:0] exp_data_q[$];
   int          ret_q[$];

   int          cyc = 0;
   int          ret_delay = 10;
   int          tb_outst = 0;
   int          max_seen = 0;
   int          wren_cnt = 0;
   int          fifo_wr_cnt = 0;
   int          done_cnt = 0;
   int          stall_viol = 0;
   int          job_done0 = 0;
   int          beat_in_burst = 0;
   logic        blocked_prev = 1'b0;
   bit          drop_mode = 1'b0;
   bit          corrupt_next = 1'b0;
   logic [31:0] pat_cnt = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Push the expected command addresses, then pulse rd_req for one cycle.
   task automatic start_job(input logic [30:0] a, input int num, input int dly);
      logic [30:0] x;
      x = a;
      for (int k = 0; k < num; k++) begin
         exp_addr_q.push_back(x);
         x = (x == ADDR_MAX) ? 31'd0 : x + 31'd4;
      end
      pat_cnt   = 32'd0;
      ret_delay = dly;
      job_done0 = done_cnt;
      bus.rd_start_addr = a;
      bus.rd_burst_num  = 16'(num);
      bus.rd_req        = 1'b1;
      tick();
      bus.rd_req        = 1'b0;
      chk("busy after accept", bus.rd_busy, 1);
   endtask

   task automatic wait_job(input int limit);
      int k;
      k = 0;
      while (done_cnt == job_done0 && k < limit) begin
         tick();
         k++;
      end
      if (done_cnt == job_done0)
         fail_now("job completion timeout");
      repeat (3) tick();
   endtask

   // Monitor outputs mid-cycle, then act as the MIG returning read data.
   always @(negedge sys_clk) begin : mon
      logic [63:0] d;
      cyc++;
      if (bus.rd_fifo_wr) begin
         fifo_wr_cnt++;
         if (exp_data_q.size() == 0)
            fail_now("unexpected fifo write");
         else
            chk("fifo data", bus.rd_fifo_din, exp_data_q.pop_front());
      end
      if (bus.app_af_wren) begin
         wren_cnt++;
         chk("cmd code", bus.app_af_cmd, 3'b001);
         if (exp_addr_q.size() == 0)
            fail_now("unexpected command");
         else
            chk("cmd addr", bus.app_af_addr, exp_addr_q.pop_front());
         if (blocked_prev)
            stall_viol++;
         ret_q.push_back(cyc + ret_delay);
         tb_outst++;
         if (tb_outst > max_seen)
            max_seen = tb_outst;
         chk("outstanding limit", tb_outst <= MAX_OUT, 1);
      end else if (bus.app_af_cmd != 3'b000) begin
         fail_now("cmd nonzero without wren");
      end
      if (bus.rd_done) begin
         done_cnt++;
         chk("busy low with done", bus.rd_busy, 0);
      end
      blocked_prev = bus.app_af_afull | bus.rd_fifo_prog_full;

      bus.rd_data_valid = 1'b0;
      if (ret_q.size() != 0 && ret_q[0] <= cyc) begin
         d = {2{pat_cnt}};
         if (corrupt_next) begin
            d[5] = ~d[5];
            corrupt_next = 1'b0;
         end
         bus.rd_data_valid    = 1'b1;
         bus.rd_data_fifo_out = d;
         if (!drop_mode)
            exp_data_q.push_back(d);
         pat_cnt = pat_cnt + 32'd1;
         beat_in_burst++;
         if (beat_in_burst == 2) begin
            beat_in_burst = 0;
            void'(ret_q.pop_front());
            if (!drop_mode)
               tb_outst--;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin : main
      int wren0, wr0, done0, k;

      vecs[0] = '{31'h0000_0000,  4, 10,  4,  8, 4};
      vecs[1] = '{31'h0000_0100, 20, 30, 20, 40, 8};
      vecs[2] = '{ADDR_MAX - 31'd4, 3, 5,  3,  6, 3};
      vecs[3] = '{31'h0000_0040,  1,  3,  1,  2, 1};

      bus.rd_req            = 1'b0;
      bus.rd_start_addr     = '0;
      bus.rd_burst_num      = '0;
      bus.app_af_afull      = 1'b0;
      bus.rd_data_valid     = 1'b0;
      bus.rd_data_fifo_out  = '0;
      bus.rd_fifo_prog_full = 1'b0;

      // reset state
      #2 reset = 1'b0;
      repeat (3) tick();
      chk("reset busy",     bus.rd_busy, 0);
      chk("reset done",     bus.rd_done, 0);
      chk("reset wren",     bus.app_af_wren, 0);
      chk("reset addr",     bus.app_af_addr, 0);
      chk("reset cmd",      bus.app_af_cmd, 0);
      chk("reset fifo_wr",  bus.rd_fifo_wr, 0);
      chk("reset fifo_din", bus.rd_fifo_din, 0);
      chk("reset err",      bus.rd_err, 0);
      reset = 1'b1;
      phy_init_done = 1'b1;
      repeat (2) tick();

      // table-driven jobs
      for (int i = 0; i < 4; i++) begin
         wren0 = wren_cnt; wr0 = fifo_wr_cnt; done0 = done_cnt;
         max_seen = 0;
         start_job(vecs[i].addr, vecs[i].num, vecs[i].delay);
         wait_job(3000);
         chk("job cmds",        wren_cnt - wren0, vecs[i].exp_cmds);
         chk("job beats",       fifo_wr_cnt - wr0, vecs[i].exp_beats);
         chk("job done count",  done_cnt - done0, 1);
         chk("job busy after",  bus.rd_busy, 0);
         chk("job max outst",   max_seen, vecs[i].exp_max_outst);
         chk("job addr left",   exp_addr_q.size(), 0);
         chk("job data left",   exp_data_q.size(), 0);
         chk("job err",         bus.rd_err, 0);
      end

      // stalls from app_af_afull and rd_fifo_prog_full, plus rd_req while busy
      wren0 = wren_cnt; wr0 = fifo_wr_cnt; done0 = done_cnt;
      stall_viol = 0;
      start_job(31'h0000_0200, 12, 4);
      tick();
      bus.app_af_afull = 1'b1;
      repeat (2) tick();
      bus.rd_start_addr = 31'h0000_7000;
      bus.rd_burst_num  = 16'd5;
      bus.rd_req        = 1'b1;
      tick();
      bus.rd_req        = 1'b0;
      repeat (2) tick();
      bus.app_af_afull = 1'b0;
      tick();
      chk("resume after afull", bus.app_af_wren, 1);
      tick();
      bus.rd_fifo_prog_full = 1'b1;
      repeat (5) tick();
      bus.rd_fifo_prog_full = 1'b0;
      tick();
      chk("resume after prog_full", bus.app_af_wren, 1);
      wait_job(3000);
      chk("stall cmds",       wren_cnt - wren0, 12);
      chk("stall beats",      fifo_wr_cnt - wr0, 24);
      chk("stall violations", stall_viol, 0);
      chk("stall done count", done_cnt - done0, 1);
      chk("stall addr left",  exp_addr_q.size(), 0);

      // zero-length job and job while calibration incomplete
      wren0 = wren_cnt; done0 = done_cnt;
      bus.rd_start_addr = 31'h0000_0400;
      bus.rd_burst_num  = 16'd0;
      bus.rd_req        = 1'b1;
      tick();
      bus.rd_req        = 1'b0;
      chk("num0 done pulse", bus.rd_done, 1);
      chk("num0 busy",       bus.rd_busy, 0);
      tick();
      chk("num0 done single", bus.rd_done, 0);
      repeat (3) tick();
      chk("num0 no cmds",    wren_cnt - wren0, 0);
      chk("num0 done count", done_cnt - done0, 1);

      phy_init_done = 1'b0;
      wren0 = wren_cnt; done0 = done_cnt;
      bus.rd_burst_num = 16'd4;
      bus.rd_req       = 1'b1;
      tick();
      bus.rd_req       = 1'b0;
      repeat (10) tick();
      chk("nophy busy",  bus.rd_busy, 0);
      chk("nophy cmds",  wren_cnt - wren0, 0);
      chk("nophy done",  done_cnt - done0, 0);
      phy_init_done = 1'b1;
      tick();

      // reset in the middle of a job
      start_job(31'h0000_0300, 6, 30);
      k = 0;
      while (tb_outst < 3 && k < 50) begin
         tick();
         k++;
      end
      if (tb_outst < 3)
         fail_now("outstanding build-up timeout");
      drop_mode = 1'b1;
      reset = 1'b0;
      #1;
      chk("midreset busy",    bus.rd_busy, 0);
      chk("midreset wren",    bus.app_af_wren, 0);
      chk("midreset cmd",     bus.app_af_cmd, 0);
      chk("midreset fifo_wr", bus.rd_fifo_wr, 0);
      chk("midreset addr",    bus.app_af_addr, 0);
      tb_outst = 0;
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) tick();
      reset = 1'b1;
      wr0 = fifo_wr_cnt;
      k = 0;
      while (ret_q.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      if (ret_q.size() != 0)
         fail_now("late beats drain timeout");
      repeat (2) tick();
      chk("late beats dropped", fifo_wr_cnt - wr0, 0);
      chk("late beats busy",    bus.rd_busy, 0);
      chk("late beats err",     bus.rd_err, 1);
      drop_mode = 1'b0;

      wren0 = wren_cnt; wr0 = fifo_wr_cnt; done0 = done_cnt;
      start_job(31'h0000_0080, 4, 6);
      chk("err cleared by new job", bus.rd_err, 0);
      wait_job(3000);
      chk("post-reset cmds",  wren_cnt - wren0, 4);
      chk("post-reset beats", fifo_wr_cnt - wr0, 8);
      chk("post-reset done",  done_cnt - done0, 1);
      chk("post-reset err",   bus.rd_err, 0);

      // corrupted beat: flagged only when the data checker is built in
      corrupt_next = 1'b1;
      wr0 = fifo_wr_cnt;
      start_job(31'h0000_00C0, 2, 4);
      wait_job(3000);
      chk("corrupt beats forwarded", fifo_wr_cnt - wr0, 4);
`ifdef RD_DATA_CHECK_EN
      chk("corrupt err set", bus.rd_err, 1);
      repeat (5) tick();
      chk("corrupt err sticky", bus.rd_err, 1);
`else
      chk("corrupt err unchecked", bus.rd_err, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
